// File: rtl/run_length_detector_pkg.sv
// Shared types and default sizing for the run-length detector.
package detector_pkg;
  typedef enum logic {
    DET_OVERLAP = 1'b0,
    DET_PULSE   = 1'b1
  } det_mode_t;

  localparam int DEF_MAX_RUN = 16;
  localparam int DEF_HIT_W   = 8;
endpackage

// File: rtl/run_length_detector_run_counter.sv
// Tracks the previous sampled bit and the saturating length of the current run.
module run_counter
  import detector_pkg::*;
#(
  parameter int MAX_RUN = DEF_MAX_RUN,
  parameter int CW      = $clog2(MAX_RUN + 1)
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          en,
  input  logic          w,
  input  logic          clr,
  output logic [CW-1:0] run_new,
  output logic          run_sat,
  output logic [CW-1:0] run_cnt
);
  logic last;
  logic cont;

  assign cont    = (run_cnt != '0) && (w == last);
  assign run_sat = cont && (run_cnt == CW'(MAX_RUN));
  assign run_new = !cont   ? CW'(1) :
                   run_sat ? run_cnt : run_cnt + CW'(1);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      last    <= 1'b0;
      run_cnt <= '0;
    end else if (en) begin
      last    <= w;
      run_cnt <= clr ? '0 : run_new;
    end
  end
endmodule

// File: rtl/run_length_detector.sv
// Run-length detector with level/pulse modes; DET_HIT_CNT_EN builds the hit counter.
module run_length_detector
  import detector_pkg::*;
#(
  parameter  int MAX_RUN = DEF_MAX_RUN,
  parameter  int HIT_W   = DEF_HIT_W,
  localparam int CW      = $clog2(MAX_RUN + 1)
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             w,
  input  logic             en,
  input  logic [CW-1:0]    run_len,
  input  logic             mode,
  input  logic             clr_cnt,
  output logic             z,
  output logic             z_val,
  output logic [CW-1:0]    run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);
  det_mode_t     md;
  logic [CW-1:0] run_new;
  logic          run_sat;
  logic          len_ok;
  logic          hit_eq;
  logic          hit;

  assign md     = det_mode_t'(mode);
  assign len_ok = (run_len != '0);
  assign hit_eq = len_ok && (run_new == run_len);
  assign hit    = (md == DET_PULSE) ? hit_eq : (len_ok && (run_new >= run_len));

  run_counter #(.MAX_RUN(MAX_RUN), .CW(CW)) u_rc (
    .clk     (clk),
    .aclr    (aclr),
    .en      (en),
    .w       (w),
    .clr     ((md == DET_PULSE) && hit),
    .run_new (run_new),
    .run_sat (run_sat),
    .run_cnt (run_cnt)
  );

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      z     <= 1'b0;
      z_val <= 1'b0;
    end else if (en) begin
      z <= hit;
      if (hit) z_val <= w;
    end else if (md == DET_PULSE) begin
      z <= 1'b0;
    end
  end

`ifdef DET_HIT_CNT_EN
  // A saturated run keeps run_new == MAX_RUN; count only the edge that reached it.
  logic cnt_inc;
  assign cnt_inc = en && hit_eq && !run_sat;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)
      hit_cnt <= '0;
    else if (clr_cnt)
      hit_cnt <= '0;
    else if (cnt_inc && (hit_cnt != {HIT_W{1'b1}}))
      hit_cnt <= hit_cnt + HIT_W'(1);
  end
`else
  logic unused_cnt;
  assign unused_cnt = clr_cnt ^ run_sat;
  assign hit_cnt    = '0;
`endif
endmodule

// File: tb/tb_run_length_detector.sv
// Randomized and directed bench for run_length_detector against a history-based model.
module tb_run_length_detector;
  localparam int MAX_RUN = 16;
  localparam int HIT_W   = 8;
  localparam int CW      = $clog2(MAX_RUN + 1);
  localparam int CNT_MAX = (1 << HIT_W) - 1;

  logic             clk = 1'b0;
  logic             aclr = 1'b0;
  logic             w = 1'b0;
  logic             en = 1'b0;
  logic [CW-1:0]    run_len = '0;
  logic             mode = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             z;
  logic             z_val;
  logic [CW-1:0]    run_cnt;
  logic [HIT_W-1:0] hit_cnt;

  int checks = 0;
  int failures = 0;

  // Model: bits sampled since reset or since the last pulse-mode hit.
  bit q[$];
  bit m_z, m_zv;
  int m_cnt;

  run_length_detector #(.MAX_RUN(MAX_RUN), .HIT_W(HIT_W)) dut (
    .clk(clk), .aclr(aclr), .w(w), .en(en), .run_len(run_len), .mode(mode),
    .clr_cnt(clr_cnt), .z(z), .z_val(z_val), .run_cnt(run_cnt), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hc(input int n);
`ifdef DET_HIT_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic int tail_len();
    int n = 0;
    if (q.size() == 0) return 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != q[q.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int capped(input int n);
    return (n > MAX_RUN) ? MAX_RUN : n;
  endfunction

  task automatic model_clear();
    q.delete();
    m_z = 0; m_zv = 0; m_cnt = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_z"},    int'(z),       int'(m_z));
    chk({tag, "_zval"}, int'(z_val),   int'(m_zv));
    chk({tag, "_rcnt"}, int'(run_cnt), capped(tail_len()));
    chk({tag, "_hcnt"}, int'(hit_cnt), hc(m_cnt));
  endtask

  task automatic step(input string tag, input bit wi, input bit ei, input int rl,
                      input bit mi, input bit ci);
    int tl, rn;
    bit hit, inc;
    w = wi; en = ei; run_len = CW'(rl); mode = mi; clr_cnt = ci;
    @(posedge clk);
    inc = 0;
    if (ei) begin
      q.push_back(wi);
      if (q.size() > 64) void'(q.pop_front());
      tl  = tail_len();
      rn  = capped(tl);
      hit = (rl != 0) && (mi ? (rn == rl) : (rn >= rl));
      inc = (rl != 0) && (rl <= MAX_RUN) && (tl == rl);
      m_z = hit;
      if (hit) m_zv = wi;
      if (mi && hit) q.delete();
    end else if (mi) begin
      m_z = 0;
    end
    if (ci) m_cnt = 0;
    else if (inc && m_cnt < CNT_MAX) m_cnt++;
    #1;
    compare_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 aclr = 1'b0;
    #1;
    model_clear();
    chk({tag, "_z"},    int'(z),       0);
    chk({tag, "_zval"}, int'(z_val),   0);
    chk({tag, "_rcnt"}, int'(run_cnt), 0);
    chk({tag, "_hcnt"}, int'(hit_cnt), 0);
    #1 aclr = 1'b1;
  endtask

  initial begin
    bit t1[7] = '{1, 0, 0, 0, 0, 0, 1};
    bit rw;
    int rl;
    bit rm;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", int'(z), 0);
    chk("rst_rcnt", int'(run_cnt), 0);
    chk("rst_hcnt", int'(hit_cnt), 0);
    @(negedge clk) aclr = 1'b1;

    // Overlap, run_len 4
    foreach (t1[i]) step("t1", t1[i], 1, 4, 0, 0);
    chk("t1_zval_final", int'(z_val), 0);
    chk("t1_hcnt_final", int'(hit_cnt), hc(1));

    // Pulse, run_len 3, eight ones
    pulse_reset("t2rst");
    for (int i = 0; i < 8; i++) step("t2", 1, 1, 3, 1, 0);
    chk("t2_hcnt_final", int'(hit_cnt), hc(2));

    // Pulse with en toggling
    pulse_reset("t3rst");
    step("t3a", 1, 1, 2, 1, 0);
    chk("t3a_z", int'(z), 0);
    step("t3b", 1, 0, 2, 1, 0);
    step("t3c", 1, 1, 2, 1, 0);
    chk("t3c_z", int'(z), 1);
    step("t3d", 1, 0, 2, 1, 0);
    chk("t3d_z", int'(z), 0);

    // Saturation at MAX_RUN in overlap mode
    pulse_reset("t4rst");
    for (int i = 0; i < 20; i++) step("t4", 0, 1, MAX_RUN, 0, 0);
    chk("t4_rcnt_final", int'(run_cnt), MAX_RUN);
    chk("t4_z_final", int'(z), 1);
    chk("t4_hcnt_final", int'(hit_cnt), hc(1));

    // Asynchronous clear mid-run
    pulse_reset("t5rst");
    step("t5a", 1, 1, 4, 0, 0);
    step("t5a", 1, 1, 4, 0, 0);
    pulse_reset("t5clr");
    step("t5b", 1, 1, 4, 0, 0);
    step("t5b", 1, 1, 4, 0, 0);
    chk("t5b_z", int'(z), 0);
    pulse_reset("t5rst2");
    for (int i = 0; i < 4; i++) step("t5c", 0, 1, 4, 0, 0);
    chk("t5c_z", int'(z), 1);

    // Hit counter saturation and clear priority
    pulse_reset("t6rst");
    for (int i = 0; i < CNT_MAX + 5; i++) step("t6", 1'($urandom_range(1)), 1, 1, 1, 0);
    chk("t6_hcnt_sat", int'(hit_cnt), hc(CNT_MAX));
    step("t6clr", 1, 1, 1, 1, 1);
    chk("t6_hcnt_clr", int'(hit_cnt), 0);
    chk("t6_z_clr", int'(z), 1);

    // Randomized traffic
    rw = 0; rl = 4; rm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rw = ~rw;
      if ($urandom_range(49) == 0) rl = $urandom_range(0, 18);
      if ($urandom_range(79) == 0) rm = ~rm;
      if ($urandom_range(299) == 0) pulse_reset("rnd_rst");
      step("rnd", rw, ($urandom_range(4) != 0), rl, rm, ($urandom_range(99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
